sd_init_seq: RTL
================

Name: sd_init_seq

Overview:
- Parametrised SPI-mode SD card initialisation sequencer; successor to the fixed CMD0/CMD8/CMD55/ACMD41/CMD16 initialiser.
- Adds power-up dummy clocks, bounded retries, a global timeout, SD v1/v2 card detection, an optional CMD58 OCR read for SDHC detection, a configurable block length, and error reporting.
- Sits between the top-level controller and the existing command engine (sd_cmd), which it drives through a valid/done handshake.

Parameters:
BLOCK_LEN, 512, byte count sent in CMD16 argument
PWRUP_CYCLES, 80, clk cycles with cs_n=1 and dummy_en=1 before CMD0 (min 74)
CMD0_RETRIES, 8, CMD0 attempts before error
ACMD41_RETRIES, 1000, CMD55+ACMD41 loop attempts before error
TIMEOUT_CYCLES, 2000000, clk cycles from leaving IDLE to forced ERROR
READ_OCR, 1, 1 = issue CMD58 after ACMD41 success; 0 = skip it

Ports:
clk  in  1  SPI-rate clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; high runs the sequence, low returns to IDLE
busy  out  1  high in any state other than IDLE/DONE/ERROR
done  out  1  high in DONE
error  out  1  high in ERROR
err_code  out  3  cause code, valid while error=1
is_sdhc  out  1  OCR bit 30 captured from CMD58
ocr  out  32  OCR captured from CMD58
cs_n  out  1  card chip select
dummy_en  out  1  high while power-up dummy clocks run
cmd_valid  out  1  command request; held until cmd_done
cmd_index  out  6  command number (engine adds 0x40)
cmd_arg  out  32  command argument
cmd_crc  out  8  CRC7 byte including stop bit
cmd_long  out  1  1 = R3/R7 response (32-bit trailer expected)
cmd_done  in  1  one-cycle pulse; cmd_r1/cmd_data valid in this cycle
cmd_r1  in  8  R1 response byte
cmd_data  in  32  R3/R7 trailer

Behaviour:
- Reset values: busy=0, done=0, error=0, err_code=0, is_sdhc=0, ocr=0, cs_n=1, dummy_en=0, cmd_valid=0, cmd_index=0, cmd_arg=0, cmd_crc=0, cmd_long=0. The state machine resets to IDLE.
- All outputs are registered.
- Handshake rules:
  - cmd_valid and the command fields are stable from assertion until the cycle in which cmd_done is sampled high.
  - cmd_valid deasserts on the next edge, for at least one cycle, before the next command.
  - cs_n=0 in every command state.
- States:
  - IDLE: when start=1, go to POWERUP and clear counters, is_sdhc and ocr.
  - POWERUP: cs_n=1, dummy_en=1 for exactly PWRUP_CYCLES cycles, then CMD0.
  - CMD0 (arg 0, crc 0x95): r1=0x01 -> CMD8. Otherwise increment the retry count; reaching CMD0_RETRIES -> ERROR code 1.
  - CMD8 (arg 0x1AA, crc 0x87, long):
    - r1=0x01 with cmd_data[11:0]=0x1AA -> v2 card, HCS=1, go to CMD55.
    - r1 bit2 set (illegal command) -> v1 card, HCS=0, go to CMD55.
    - Anything else -> ERROR code 2.
  - CMD55 (arg 0, crc 0x65): r1 in {0x00, 0x01} -> ACMD41. Otherwise ERROR code 3.
  - ACMD41 (arg HCS<<30, crc 0x77 for HCS=1, 0xE5 for HCS=0):
    - r1=0x00 -> CMD58 if READ_OCR=1 and card is v2, else CMD16.
    - r1=0x01 -> increment the loop count and go to CMD55. Reaching ACMD41_RETRIES -> ERROR code 3.
    - Anything else -> ERROR code 3.
  - CMD58 (arg 0, crc 0xFD, long): r1=0x00 -> latch ocr=cmd_data and is_sdhc=cmd_data[30], then go to CMD16 if is_sdhc=0, else DONE. Otherwise ERROR code 6.
  - CMD16 (arg BLOCK_LEN, crc 0xFF): r1=0x00 -> DONE. Otherwise ERROR code 5.
  - DONE and ERROR: cs_n=1. Hold until start=0.
- Timeout: a 32-bit cycle counter runs in every non-IDLE, non-terminal state. Reaching TIMEOUT_CYCLES -> ERROR code 4. This has priority over a simultaneous cmd_done, and cmd_valid drops on the transition.
- start=0 in any state -> IDLE on the next edge. cmd_valid drops; done, error and err_code clear; ocr and is_sdhc hold.
- Restarting requires start to go low then high again.
- Asynchronous reset mid-command forces the reset values immediately. The command engine must tolerate cmd_valid dropping without completion.
- Counters saturate and never wrap.

Decomposition:
- Package sd_pkg holds:
  - the state enum;
  - command index constants (0, 8, 16, 41, 55, 58) and their CRC bytes;
  - the err_code enum: 0 none, 1 CMD0, 2 CMD8, 3 ACMD41, 4 timeout, 5 CMD16, 6 CMD58.
- One sub-module, sd_timeout_ctr: a parametrised saturating counter with clear/enable/expired, instanced for the timeout and the retry counts.

Test Plan:
- v2 SDHC card model (CMD0 0x01, CMD8 0x01 with 0x1AA, ACMD41 0x01 twice then 0x00, OCR 0xC0FF8000) -> 80 dummy cycles, then sequence CMD0, CMD8, CMD55/ACMD41 x3, CMD58, DONE. is_sdhc=1, no CMD16 issued.
- v1 card (CMD8 r1=0x05, ACMD41 0x00, BLOCK_LEN=512) -> ACMD41 arg 0x00000000, CMD58 skipped, CMD16 arg 0x200, done=1.
- CMD0 always returns 0xFF with CMD0_RETRIES=8 -> exactly 8 CMD0 requests, then error=1, err_code=1, cs_n=1.
- Card never answers cmd_done with TIMEOUT_CYCLES=1000 -> error=1 and err_code=4 at cycle 1000±1 after start, cmd_valid=0.
- start dropped during ACMD41 with cmd_done in the same cycle -> IDLE next cycle, cmd_valid=0, done=0; re-raising start restarts from POWERUP.
- rst_n asserted mid-CMD8 -> all outputs at reset values without waiting for a clk edge.

Source files
------------

// File: rtl/sd_init_seq_pkg.sv
// Shared types and constants for the SPI-mode SD card initialisation sequencer.
// Holds the FSM state set, command indices with their CRC bytes, and error causes.
package sd_pkg;

   typedef enum logic [3:0] {
      S_IDLE, S_POWERUP, S_CMD0, S_CMD8, S_CMD55,
      S_ACMD41, S_CMD58, S_CMD16, S_DONE, S_ERROR
   } sd_state_e;

   typedef enum logic [2:0] {
      ERR_NONE    = 3'd0,
      ERR_CMD0    = 3'd1,
      ERR_CMD8    = 3'd2,
      ERR_ACMD41  = 3'd3,
      ERR_TIMEOUT = 3'd4,
      ERR_CMD16   = 3'd5,
      ERR_CMD58   = 3'd6
   } sd_err_e;

   localparam logic [5:0] CMD0_IDX   = 6'd0;
   localparam logic [5:0] CMD8_IDX   = 6'd8;
   localparam logic [5:0] CMD16_IDX  = 6'd16;
   localparam logic [5:0] ACMD41_IDX = 6'd41;
   localparam logic [5:0] CMD55_IDX  = 6'd55;
   localparam logic [5:0] CMD58_IDX  = 6'd58;

   localparam logic [7:0] CMD0_CRC       = 8'h95;
   localparam logic [7:0] CMD8_CRC       = 8'h87;
   localparam logic [7:0] CMD16_CRC      = 8'hFF;
   localparam logic [7:0] ACMD41_CRC_HCS = 8'h77;
   localparam logic [7:0] ACMD41_CRC_V1  = 8'hE5;
   localparam logic [7:0] CMD55_CRC      = 8'h65;
   localparam logic [7:0] CMD58_CRC      = 8'hFD;

   // Voltage range 0x1 plus check pattern 0xAA, echoed back by v2 cards
   localparam logic [11:0] CMD8_CHECK = 12'h1AA;

   function automatic logic is_cmd_state(sd_state_e s);
      return s inside {S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD58, S_CMD16};
   endfunction

   function automatic logic is_active(sd_state_e s);
      return !(s inside {S_IDLE, S_DONE, S_ERROR});
   endfunction

endpackage

// File: rtl/sd_init_seq_if.sv
// Request/response link between the init sequencer and the sd_cmd command engine.
// cmd_valid and fields hold until the cycle cmd_done is high; cmd_r1/cmd_data are valid only then.
interface sd_cmd_if;
   logic        cmd_valid;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic [7:0]  cmd_crc;
   logic        cmd_long;
   logic        cmd_done;
   logic [7:0]  cmd_r1;
   logic [31:0] cmd_data;

   modport master (
      output cmd_valid, cmd_index, cmd_arg, cmd_crc, cmd_long,
      input  cmd_done, cmd_r1, cmd_data
   );

   modport slave (
      input  cmd_valid, cmd_index, cmd_arg, cmd_crc, cmd_long,
      output cmd_done, cmd_r1, cmd_data
   );
endinterface

// File: rtl/sd_timeout_ctr.sv
// Saturating up-counter with synchronous clear; expired_o is high once the count reaches LIMIT.
// Used for the power-up window, the global timeout and the retry budgets.
module sd_timeout_ctr #(
   parameter int unsigned     W     = 32,
   parameter logic [W-1:0]    LIMIT = '1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && !expired_o) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired_o = (cnt_q >= LIMIT);

endmodule

// File: rtl/sd_init_seq.sv
// SPI-mode SD card initialisation sequencer: power-up clocks, CMD0/8/55/ACMD41/58/16 with
// retries and a global timeout, driving the command engine over sd_cmd_if.
module sd_init_seq
   import sd_pkg::*;
#(
   parameter int unsigned BLOCK_LEN      = 512,
   parameter int unsigned PWRUP_CYCLES   = 80,
   parameter int unsigned CMD0_RETRIES   = 8,
   parameter int unsigned ACMD41_RETRIES = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 2000000,
   parameter bit          READ_OCR       = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [2:0]  err_code,
   output logic        is_sdhc,
   output logic [31:0] ocr,
   output logic        cs_n,
   output logic        dummy_en,
   output sd_state_e   dbg_state,
   sd_cmd_if.master    bus
);

   sd_state_e   state_q, state_d;
   sd_err_e     err_q, err_d;
   logic        hcs_q, hcs_d;
   logic        busy_q, done_q, error_q, sdhc_q, cs_n_q, dummy_q;
   logic [31:0] ocr_q;
   logic        cmd_valid_q, cmd_long_q;
   logic [5:0]  cmd_index_q;
   logic [31:0] cmd_arg_q;
   logic [7:0]  cmd_crc_q;

   logic ack, cmd0_fail, acmd_loop, ocr_take;
   logic pwr_exp, tmo_exp, cmd0_exp, acmd_exp;
   logic in_idle;

   assign ack     = cmd_valid_q & bus.cmd_done;
   assign in_idle = (state_q == S_IDLE);

   sd_timeout_ctr #(.W(32), .LIMIT(32'(PWRUP_CYCLES - 1))) u_pwr_ctr (
      .clk(clk), .rst_n(rst_n), .clr_i(state_q != S_POWERUP),
      .en_i(state_q == S_POWERUP), .expired_o(pwr_exp)
   );

   sd_timeout_ctr #(.W(32), .LIMIT(32'(TIMEOUT_CYCLES - 1))) u_tmo_ctr (
      .clk(clk), .rst_n(rst_n), .clr_i(in_idle),
      .en_i(is_active(state_q)), .expired_o(tmo_exp)
   );

   sd_timeout_ctr #(.W(32), .LIMIT(32'(CMD0_RETRIES - 1))) u_cmd0_ctr (
      .clk(clk), .rst_n(rst_n), .clr_i(in_idle),
      .en_i(cmd0_fail), .expired_o(cmd0_exp)
   );

   sd_timeout_ctr #(.W(32), .LIMIT(32'(ACMD41_RETRIES - 1))) u_acmd_ctr (
      .clk(clk), .rst_n(rst_n), .clr_i(in_idle),
      .en_i(acmd_loop), .expired_o(acmd_exp)
   );

   always_comb begin
      state_d   = state_q;
      err_d     = err_q;
      hcs_d     = hcs_q;
      cmd0_fail = 1'b0;
      acmd_loop = 1'b0;
      ocr_take  = 1'b0;
      // start low wins over everything; timeout wins over a same-cycle cmd_done
      if (!start) begin
         state_d = S_IDLE;
         err_d   = ERR_NONE;
      end else if (is_active(state_q) && tmo_exp) begin
         state_d = S_ERROR;
         err_d   = ERR_TIMEOUT;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = S_POWERUP;
               err_d   = ERR_NONE;
               hcs_d   = 1'b0;
            end
            S_POWERUP: if (pwr_exp) state_d = S_CMD0;
            S_CMD0: if (ack) begin
               if (bus.cmd_r1 == 8'h01) state_d = S_CMD8;
               else if (cmd0_exp) begin state_d = S_ERROR; err_d = ERR_CMD0; end
               else cmd0_fail = 1'b1;
            end
            S_CMD8: if (ack) begin
               if (bus.cmd_r1 == 8'h01 && bus.cmd_data[11:0] == CMD8_CHECK) begin
                  hcs_d = 1'b1; state_d = S_CMD55;
               end else if (bus.cmd_r1[2]) begin
                  hcs_d = 1'b0; state_d = S_CMD55;
               end else begin
                  state_d = S_ERROR; err_d = ERR_CMD8;
               end
            end
            S_CMD55: if (ack) begin
               if (bus.cmd_r1 == 8'h00 || bus.cmd_r1 == 8'h01) state_d = S_ACMD41;
               else begin state_d = S_ERROR; err_d = ERR_ACMD41; end
            end
            S_ACMD41: if (ack) begin
               if (bus.cmd_r1 == 8'h00) begin
                  state_d = (READ_OCR && hcs_q) ? S_CMD58 : S_CMD16;
               end else if (bus.cmd_r1 == 8'h01 && !acmd_exp) begin
                  acmd_loop = 1'b1; state_d = S_CMD55;
               end else begin
                  state_d = S_ERROR; err_d = ERR_ACMD41;
               end
            end
            S_CMD58: if (ack) begin
               if (bus.cmd_r1 == 8'h00) begin
                  ocr_take = 1'b1;
                  state_d  = bus.cmd_data[30] ? S_DONE : S_CMD16;
               end else begin
                  state_d = S_ERROR; err_d = ERR_CMD58;
               end
            end
            S_CMD16: if (ack) begin
               if (bus.cmd_r1 == 8'h00) state_d = S_DONE;
               else begin state_d = S_ERROR; err_d = ERR_CMD16; end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         err_q       <= ERR_NONE;
         hcs_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         sdhc_q      <= 1'b0;
         ocr_q       <= '0;
         cs_n_q      <= 1'b1;
         dummy_q     <= 1'b0;
         cmd_valid_q <= 1'b0;
         cmd_index_q <= '0;
         cmd_arg_q   <= '0;
         cmd_crc_q   <= '0;
         cmd_long_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         hcs_q   <= hcs_d;
         busy_q  <= is_active(state_d);
         done_q  <= (state_d == S_DONE);
         error_q <= (state_d == S_ERROR);
         cs_n_q  <= !is_cmd_state(state_d);
         dummy_q <= (state_d == S_POWERUP);
         if (in_idle && state_d == S_POWERUP) begin
            ocr_q  <= '0;
            sdhc_q <= 1'b0;
         end else if (ocr_take) begin
            ocr_q  <= bus.cmd_data;
            sdhc_q <= bus.cmd_data[30];
         end
         // Completion always costs one idle cycle before the next request
         if (!is_cmd_state(state_d) || ack) begin
            cmd_valid_q <= 1'b0;
         end else if (!cmd_valid_q) begin
            cmd_valid_q <= 1'b1;
            unique case (state_d)
               S_CMD0:   begin cmd_index_q <= CMD0_IDX;   cmd_arg_q <= '0;            cmd_crc_q <= CMD0_CRC;  cmd_long_q <= 1'b0; end
               S_CMD8:   begin cmd_index_q <= CMD8_IDX;   cmd_arg_q <= 32'h0000_01AA; cmd_crc_q <= CMD8_CRC;  cmd_long_q <= 1'b1; end
               S_CMD55:  begin cmd_index_q <= CMD55_IDX;  cmd_arg_q <= '0;            cmd_crc_q <= CMD55_CRC; cmd_long_q <= 1'b0; end
               S_ACMD41: begin
                  cmd_index_q <= ACMD41_IDX;
                  cmd_arg_q   <= {1'b0, hcs_q, 30'd0};
                  cmd_crc_q   <= hcs_q ? ACMD41_CRC_HCS : ACMD41_CRC_V1;
                  cmd_long_q  <= 1'b0;
               end
               S_CMD58:  begin cmd_index_q <= CMD58_IDX;  cmd_arg_q <= '0;              cmd_crc_q <= CMD58_CRC; cmd_long_q <= 1'b1; end
               S_CMD16:  begin cmd_index_q <= CMD16_IDX;  cmd_arg_q <= 32'(BLOCK_LEN);  cmd_crc_q <= CMD16_CRC; cmd_long_q <= 1'b0; end
               default: ;
            endcase
         end
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign err_code      = err_q;
   assign is_sdhc       = sdhc_q;
   assign ocr           = ocr_q;
   assign cs_n          = cs_n_q;
   assign dummy_en      = dummy_q;
   assign dbg_state     = state_q;
   assign bus.cmd_valid = cmd_valid_q;
   assign bus.cmd_index = cmd_index_q;
   assign bus.cmd_arg   = cmd_arg_q;
   assign bus.cmd_crc   = cmd_crc_q;
   assign bus.cmd_long  = cmd_long_q;

endmodule
